// File: rtl/uart_key_pkg.sv
// Shared constants, FSM encoding and alias lookup for the UART key decoder.
package uart_key_pkg;

    localparam logic [7:0] ASCII_ESC      = 8'h1B;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_O        = 8'h4F;
    localparam logic [7:0] CSI_UP         = 8'h41;
    localparam logic [7:0] CSI_DOWN       = 8'h42;
    localparam logic [7:0] CSI_RIGHT      = 8'h43;
    localparam logic [7:0] CSI_LEFT       = 8'h44;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_RIGHT = 2;
    localparam int DIR_LEFT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GOT_ESC = 2'd1,
        ST_GOT_CSI = 2'd2
    } key_state_t;

    // One-hot direction hit for byte b; scanning from the top down lets the
    // lowest direction index overwrite any higher match. ESC never matches.
    function automatic logic [3:0] alias_match(input logic [63:0] key_alias,
                                               input logic [7:0]  b);
        logic [7:0] a0;
        logic [7:0] a1;
        alias_match = '0;
        for (int d = 3; d >= 0; d--) begin
            a0 = key_alias[63-16*d -: 8];
            a1 = key_alias[55-16*d -: 8];
            if ((b != ASCII_ESC) && ((b == a0) || (b == a1))) begin
                alias_match    = '0;
                alias_match[d] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_key_decoder_key_hold_timer.sv
// Per-direction hold tracker: a press (re)loads the countdown, held drops once it has run out.
module key_hold_timer
    import uart_key_pkg::*;
#(
    parameter logic [31:0] HOLD_CYCLES = 32'd60_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic press,
    output logic held
);
    localparam int HW = $clog2(HOLD_CYCLES + 32'd1);

    logic [HW-1:0] r_cnt;
    logic          r_held;

    assign held = r_held;

    // Reload on press; otherwise count down and release the cycle after reaching zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_held <= 1'b0;
        end else if (press) begin
            r_cnt  <= HW'(HOLD_CYCLES);
            r_held <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - HW'(1);
        end else begin
            r_held <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, one-cycle rx_we per good frame.
module uart_rx #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter int          WORD_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  full,
    output logic                  rx_we,
    output logic [WORD_WIDTH-1:0] rx_data
);
    localparam logic [31:0] CPB = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int          CW  = $clog2(CPB);
    localparam int          BW  = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 32'd1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CPB / 32'd2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t             r_state, w_state_nxt;
    logic [1:0]            r_sync;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [BW-1:0]         r_bit, w_bit_nxt;
    logic [WORD_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_we, w_we_nxt;
    logic                  w_rx_s;

    assign w_rx_s  = r_sync[1];
    assign rx_we   = r_we;
    assign rx_data = r_shift;

    // Synchronise the pin and hold receiver state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_we    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_we    <= w_we_nxt;
        end
    end

    // Frame sequencing: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_we_nxt    = 1'b0;
        case (r_state)
            RX_IDLE: if (!w_rx_s) begin
                w_state_nxt = RX_START;
                w_cnt_nxt   = HALF_BIT;
            end
            RX_START: if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
                else if (!w_rx_s) begin
                    w_state_nxt = RX_DATA;
                    w_cnt_nxt   = BIT_LAST;
                    w_bit_nxt   = '0;
                end else w_state_nxt = RX_IDLE;
            RX_DATA: if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
                else begin
                    w_shift_nxt = {w_rx_s, r_shift[WORD_WIDTH-1:1]};
                    w_cnt_nxt   = BIT_LAST;
                    if (r_bit == BW'(WORD_WIDTH - 1)) w_state_nxt = RX_STOP;
                    else w_bit_nxt = r_bit + BW'(1);
                end
            RX_STOP: if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
                else begin
                    w_we_nxt    = w_rx_s && !full;
                    w_state_nxt = RX_IDLE;
                end
            default: w_state_nxt = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_key_decoder.sv
// UART direction-key decoder: single-byte aliases plus ESC [ / ESC O cursor sequences.
module uart_key_decoder
    import uart_key_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [63:0] KEY_ALIAS       = 64'h7555_6444_7252_6C4C,
    parameter logic [31:0] ESC_TIMEOUT     = 32'd1_000_000,
    parameter logic [31:0] HOLD_CYCLES     = 32'd60_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] key_pulse,
    output logic [3:0] key_held,
    output logic       esc_pulse,
    output logic       seq_err,
    output logic       char_valid,
    output logic [7:0] char_data
);
    localparam int TW = $clog2(ESC_TIMEOUT + 32'd1);

    logic          w_rx_we;
    logic [7:0]    w_rx_data;
    key_state_t    r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [3:0]    w_key_nxt, w_alias;
    logic          w_esc_nxt, w_err_nxt, w_cv_nxt, w_reproc;
    logic [3:0]    r_key_pulse;
    logic          r_esc_pulse, r_seq_err, r_char_valid;
    logic [7:0]    r_char_data;

    uart_rx #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
        .BAUD_RATE      (BAUD_RATE),
        .WORD_WIDTH     (8)
    ) u_uart_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .full   (1'b0),
        .rx_we  (w_rx_we),
        .rx_data(w_rx_data)
    );

    assign w_alias = alias_match(KEY_ALIAS, w_rx_data);

    // FSM state and escape timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Decode: a non-sequence byte after ESC flags the ESC and is then treated as a fresh byte.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_key_nxt   = '0;
        w_esc_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_cv_nxt    = 1'b0;
        w_reproc    = 1'b0;
        case (r_state)
            ST_IDLE: w_reproc = w_rx_we;
            ST_GOT_ESC: begin
                if (w_rx_we) begin
                    if (w_rx_data == ASCII_LBRACKET || w_rx_data == ASCII_O) begin
                        w_state_nxt = ST_GOT_CSI;
                        w_timer_nxt = TW'(ESC_TIMEOUT);
                    end else begin
                        w_esc_nxt = 1'b1;
                        w_reproc  = 1'b1;
                    end
                end else if (r_timer == '0) begin
                    w_esc_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_GOT_CSI: begin
                if (w_rx_we) begin
                    w_state_nxt = ST_IDLE;
                    case (w_rx_data)
                        CSI_UP:    w_key_nxt[DIR_UP]    = 1'b1;
                        CSI_DOWN:  w_key_nxt[DIR_DOWN]  = 1'b1;
                        CSI_RIGHT: w_key_nxt[DIR_RIGHT] = 1'b1;
                        CSI_LEFT:  w_key_nxt[DIR_LEFT]  = 1'b1;
                        default:   w_err_nxt            = 1'b1;
                    endcase
                end else if (r_timer == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_reproc) begin
            if (w_rx_data == ASCII_ESC) begin
                w_state_nxt = ST_GOT_ESC;
                w_timer_nxt = TW'(ESC_TIMEOUT);
            end else begin
                w_state_nxt = ST_IDLE;
                if (w_alias != '0) w_key_nxt = w_alias;
                else               w_cv_nxt  = 1'b1;
            end
        end
    end

    // Register all strobes; char_data keeps its last passthrough byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_pulse  <= '0;
            r_esc_pulse  <= 1'b0;
            r_seq_err    <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_data  <= '0;
        end else begin
            r_key_pulse  <= w_key_nxt;
            r_esc_pulse  <= w_esc_nxt;
            r_seq_err    <= w_err_nxt;
            r_char_valid <= w_cv_nxt;
            if (w_cv_nxt) r_char_data <= w_rx_data;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_hold
        key_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
            .clk  (clk),
            .rst  (rst),
            .press(w_key_nxt[g]),
            .held (key_held[g])
        );
    end

    assign key_pulse  = r_key_pulse;
    assign esc_pulse  = r_esc_pulse;
    assign seq_err    = r_seq_err;
    assign char_valid = r_char_valid;
    assign char_data  = r_char_data;
endmodule
